instr_queue: RTL

Parametrised instruction register with a small prefetch queue. Instruction words are captured from the shared data bus into a DEPTH-entry FIFO. The head entry is presented to the control unit already split into opcode, flag, shift and register-select fields. It replaces the single-entry instruction register, so the fetch logic can run ahead of execution and the control unit can discard prefetched words on a branch.

---
 rtl/instr_queue_pkg.sv | 57 +++++
 rtl/instr_field_decode.sv | 50 +++++
 rtl/instr_queue.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/instr_queue_pkg.sv
// ---------------------------------------------------------------------------
// instr_queue_pkg
// Shared definitions for the instruction prefetch queue:
//   - default widths for the queue and its instruction format
//   - field-position helpers, as functions of WIDTH / OPCODE_W / REG_W,
//     shared by the decoder and the debug monitor
//   - count update encoding used by the queue bookkeeping
// ---------------------------------------------------------------------------
package instr_queue_pkg;

    localparam int IQ_WIDTH    = 16;
    localparam int IQ_DEPTH    = 4;
    localparam int IQ_OPCODE_W = 4;
    localparam int IQ_REG_W    = 3;

    // Opcode occupies the top OPCODE_W bits of the word.
    function automatic int opcode_msb(input int width);
        return width - 1;
    endfunction

    // Single flag bit directly below the opcode.
    function automatic int s_flag_pos(input int width, input int opcode_w);
        return width - opcode_w - 1;
    endfunction

    // Two-bit shift field directly below the flag.
    function automatic int shift_msb(input int width, input int opcode_w);
        return width - opcode_w - 2;
    endfunction

    // rd_2 starts at the flag bit, so it aliases flag and shift on purpose.
    function automatic int rd2_msb(input int width, input int opcode_w);
        return width - opcode_w - 1;
    endfunction

    // The three low register selects are packed at the bottom of the word.
    function automatic int rd1_msb(input int reg_w);
        return 3 * reg_w - 1;
    endfunction

    function automatic int rs1_msb(input int reg_w);
        return 2 * reg_w - 1;
    endfunction

    function automatic int rs2_msb(input int reg_w);
        return reg_w - 1;
    endfunction

    // Count update selector, built as {push_eff, pop_eff}.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_DEC  = 2'b01,
        CNT_INC  = 2'b10,
        CNT_BOTH = 2'b11
    } cnt_op_e;

endpackage

// File: rtl/instr_field_decode.sv
// ---------------------------------------------------------------------------
// instr_field_decode
// Purely combinational slicer that splits an instruction word into its
// control fields. It is shared with the disassembly/debug monitor, so it has
// no state and no notion of validity. The caller zeroes the word when there
// is nothing to decode.
// Ports:
//   i_word     instruction word
//   o_opcode   top OPCODE_W bits
//   o_s_flag   bit just below the opcode
//   o_shift    2-bit field below the flag
//   o_rd_2     REG_W bits starting at the flag (overlaps flag/shift)
//   o_rd_1     bits [3*REG_W-1 -: REG_W]
//   o_rs_1     bits [2*REG_W-1 -: REG_W]
//   o_rs_2     bits [REG_W-1:0]
// ---------------------------------------------------------------------------
module instr_field_decode
    import instr_queue_pkg::*;
#(
    parameter int WIDTH    = IQ_WIDTH,
    parameter int OPCODE_W = IQ_OPCODE_W,
    parameter int REG_W    = IQ_REG_W
) (
    input  logic [WIDTH-1:0]    i_word,
    output logic [OPCODE_W-1:0] o_opcode,
    output logic                o_s_flag,
    output logic [1:0]          o_shift,
    output logic [REG_W-1:0]    o_rd_2,
    output logic [REG_W-1:0]    o_rd_1,
    output logic [REG_W-1:0]    o_rs_1,
    output logic [REG_W-1:0]    o_rs_2
);

    localparam int LP_OPC_MSB   = opcode_msb(WIDTH);
    localparam int LP_FLAG_POS  = s_flag_pos(WIDTH, OPCODE_W);
    localparam int LP_SHIFT_MSB = shift_msb(WIDTH, OPCODE_W);
    localparam int LP_RD2_MSB   = rd2_msb(WIDTH, OPCODE_W);
    localparam int LP_RD1_MSB   = rd1_msb(REG_W);
    localparam int LP_RS1_MSB   = rs1_msb(REG_W);
    localparam int LP_RS2_MSB   = rs2_msb(REG_W);

    assign o_opcode = i_word[LP_OPC_MSB -: OPCODE_W];
    assign o_s_flag = i_word[LP_FLAG_POS];
    assign o_shift  = i_word[LP_SHIFT_MSB -: 2];
    assign o_rd_2   = i_word[LP_RD2_MSB -: REG_W];
    assign o_rd_1   = i_word[LP_RD1_MSB -: REG_W];
    assign o_rs_1   = i_word[LP_RS1_MSB -: REG_W];
    assign o_rs_2   = i_word[LP_RS2_MSB -: REG_W];

endmodule

// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
// Instruction register with a DEPTH-entry prefetch FIFO. Fetch pushes words
// from the data bus, and the control unit retires the head with pop. A
// flush discards everything that was prefetched, for example on a branch.
// The head entry is presented raw and already split into control fields.
// Ports:
//   clk, reset     clock; synchronous active-high reset (clears storage too)
//   i_data_in      instruction word from the bus
//   i_push         capture i_data_in this cycle
//   i_pop          retire the head entry this cycle
//   i_flush        discard all entries (storage contents left as-is)
//   o_head_valid   queue non-empty
//   o_full         count == DEPTH
//   o_count        occupied entries
//   o_overflow     sticky: push while full without a concurrent pop
//   o_head_word    head entry, zero when empty
//   o_opcode .. o_rd_2   decoded fields of o_head_word
// ---------------------------------------------------------------------------
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int WIDTH    = IQ_WIDTH,
    parameter int DEPTH    = IQ_DEPTH,
    parameter int OPCODE_W = IQ_OPCODE_W,
    parameter int REG_W    = IQ_REG_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           i_data_in,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_head_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow,
    output logic [WIDTH-1:0]           o_head_word,
    output logic [OPCODE_W-1:0]        o_opcode,
    output logic                       o_s_flag,
    output logic [1:0]                 o_shift,
    output logic [REG_W-1:0]           o_rd_1,
    output logic [REG_W-1:0]           o_rs_1,
    output logic [REG_W-1:0]           o_rs_2,
    output logic [REG_W-1:0]           o_rd_2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0]    LP_PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    LP_PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]    LP_CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    LP_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    LP_CNT_FULL = CW'(DEPTH);
    localparam logic [WIDTH-1:0] LP_WORD_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rp;
    logic [PW-1:0]    r_wp;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_head_valid;
    logic             w_push_eff;
    logic             w_pop_eff;
    logic             w_drop;
    cnt_op_e          w_cnt_op;
    logic [WIDTH-1:0] w_head_word;

    // Status flags and the accept/retire decisions for this edge.
    always_comb begin
        w_full       = (r_count == LP_CNT_FULL);
        w_head_valid = (r_count != LP_CNT_ZERO);
        // A pop on a full queue frees the slot this push lands in.
        w_push_eff   = i_push & (~w_full | i_pop);
        w_pop_eff    = i_pop & w_head_valid;
        w_drop       = i_push & w_full & ~i_pop;
        w_cnt_op     = cnt_op_e'({w_push_eff, w_pop_eff});
    end

    // Head word selection. Zero when empty, so every decoded field reads 0.
    always_comb begin
        w_head_word = LP_WORD_ZERO;
        if (w_head_valid) begin
            w_head_word = r_mem[r_rp];
        end else begin
            w_head_word = LP_WORD_ZERO;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rp       <= LP_PTR_ZERO;
            r_wp       <= LP_PTR_ZERO;
            r_count    <= LP_CNT_ZERO;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_rp       <= LP_PTR_ZERO;
            r_wp       <= LP_PTR_ZERO;
            r_count    <= LP_CNT_ZERO;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_eff) begin
                r_wp <= r_wp + LP_PTR_ONE;
            end else begin
                r_wp <= r_wp;
            end
            if (w_pop_eff) begin
                r_rp <= r_rp + LP_PTR_ONE;
            end else begin
                r_rp <= r_rp;
            end
            case (w_cnt_op)
                CNT_INC:  r_count <= r_count + LP_CNT_ONE;
                CNT_DEC:  r_count <= r_count - LP_CNT_ONE;
                default:  r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // Storage array. Reset scrubs it, while flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= LP_WORD_ZERO;
            end
        end else if (i_flush) begin
            r_mem <= r_mem;
        end else if (w_push_eff) begin
            r_mem[r_wp] <= i_data_in;
        end else begin
            r_mem <= r_mem;
        end
    end

    assign o_head_valid = w_head_valid;
    assign o_full       = w_full;
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;
    assign o_head_word  = w_head_word;

    instr_field_decode #(
        .WIDTH    (WIDTH),
        .OPCODE_W (OPCODE_W),
        .REG_W    (REG_W)
    ) u_decode (
        .i_word   (w_head_word),
        .o_opcode (o_opcode),
        .o_s_flag (o_s_flag),
        .o_shift  (o_shift),
        .o_rd_2   (o_rd_2),
        .o_rd_1   (o_rd_1),
        .o_rs_1   (o_rs_1),
        .o_rs_2   (o_rs_2)
    );

endmodule
